// File: rtl/palette_pkg.sv
// Shared colour and skid-FIFO entry types for the palette lookup path.
// PALETTE_TRANSPARENT_EN adds a transparent flag to each FIFO entry.
package palette_pkg;

    localparam int COL_WIDTH        = 16;
    localparam int BYTES_PER_COLOUR = 2;

    typedef logic [COL_WIDTH-1:0] col_t;

    typedef struct packed {
        col_t colour;
        logic last;
`ifdef PALETTE_TRANSPARENT_EN
        logic transparent;
`endif
    } fifo_entry_t;

endpackage

// File: rtl/palette_skid_fifo.sv
// Register skid FIFO of palette entries: head always presented, same-cycle
// push and pop, occupancy count exported for upstream flow control.
module palette_skid_fifo
    import palette_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fifo_entry_t            wr_entry,
    input  logic                   pop,
    output fifo_entry_t            head,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t          mem [DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic                 do_pop;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + COUNT_WIDTH'(1);
            end else if (!push && do_pop) begin
                count <= count - COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/palette_pixel_lookup.sv
// Streaming palette index to RGB565 converter with line-end tagging.
// Optional PALETTE_TRANSPARENT_EN flags index-0 pixels on m_col_transparent.
module palette_pixel_lookup
    import palette_pkg::*;
#(
    parameter int OFFSET      = 0,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 8,
    parameter int BANK_WIDTH  = 4,
    parameter int LINE_WIDTH  = 400,
    parameter int SKID_DEPTH  = 3
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [INDEX_WIDTH-1:0] s_pix_index,
    input  logic                   s_pix_valid,
    output logic                   s_pix_ready,
    input  logic [BANK_WIDTH-1:0]  palette_bank,
    output logic [ADDR_WIDTH-1:0]  portb_address,
    input  logic [DATA_WIDTH-1:0]  portb_data,
    output logic [DATA_WIDTH-1:0]  m_col_data,
    output logic                   m_col_last,
    output logic                   m_col_valid,
`ifdef PALETTE_TRANSPARENT_EN
    output logic                   m_col_transparent,
`endif
    input  logic                   m_col_ready
);

    localparam int CNT_WIDTH   = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int COUNT_WIDTH = $clog2(SKID_DEPTH + 1);

    logic                   run;
    logic                   pending;
    logic                   pix_last;
    logic                   accept;
    logic                   at_line_end;
    logic                   pop;
    logic [CNT_WIDTH-1:0]   line_cnt;
    logic [COUNT_WIDTH-1:0] fifo_count;
    fifo_entry_t            wr_entry;
    fifo_entry_t            head;
`ifdef PALETTE_TRANSPARENT_EN
    logic                   pix_transparent;
`endif

    // The word in flight (pending) reserves a FIFO slot, so ready never depends on m_col_ready.
    assign s_pix_ready = run && ((32'(fifo_count) + 32'(pending)) < 32'(SKID_DEPTH));
    assign accept      = s_pix_valid && s_pix_ready;
    assign at_line_end = (line_cnt == CNT_WIDTH'(LINE_WIDTH - 1));

    // Address parks at the table base until the first clock out of reset.
    assign portb_address = run
        ? ADDR_WIDTH'(OFFSET) + ADDR_WIDTH'(32'({palette_bank, s_pix_index}) * BYTES_PER_COLOUR)
        : ADDR_WIDTH'(OFFSET);

    always_ff @(posedge aclk) begin
        if (areset) begin
            run      <= 1'b0;
            pending  <= 1'b0;
            pix_last <= 1'b0;
            line_cnt <= '0;
`ifdef PALETTE_TRANSPARENT_EN
            pix_transparent <= 1'b0;
`endif
        end else begin
            run     <= 1'b1;
            pending <= accept;
            if (accept) begin
                pix_last <= at_line_end;
                line_cnt <= at_line_end ? '0 : line_cnt + CNT_WIDTH'(1);
`ifdef PALETTE_TRANSPARENT_EN
                pix_transparent <= (s_pix_index == '0);
`endif
            end
        end
    end

    always_comb begin
        wr_entry        = '0;
        wr_entry.colour = col_t'(portb_data);
        wr_entry.last   = pix_last;
`ifdef PALETTE_TRANSPARENT_EN
        wr_entry.transparent = pix_transparent;
`endif
    end

    palette_skid_fifo #(
        .DEPTH       (SKID_DEPTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_fifo (
        .clk      (aclk),
        .reset    (areset),
        .push     (pending),
        .wr_entry (wr_entry),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

    assign m_col_valid = (fifo_count != '0);
    assign pop         = m_col_valid && m_col_ready;
    assign m_col_data  = DATA_WIDTH'(head.colour);
    assign m_col_last  = head.last;
`ifdef PALETTE_TRANSPARENT_EN
    assign m_col_transparent = head.transparent;
`endif

endmodule

// File: tb/tb_palette_pixel_lookup.sv
// Directed bench for palette_pixel_lookup with a behavioural colour table
// (table[k] = A000 + k, OFFSET 8000, LINE_WIDTH 4).
module tb_palette_pixel_lookup;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  s_pix_index;
    logic        s_pix_valid;
    logic        s_pix_ready;
    logic [3:0]  palette_bank;
    logic [15:0] portb_address;
    logic [15:0] portb_data;
    logic [15:0] m_col_data;
    logic        m_col_last;
    logic        m_col_valid;
    logic        m_col_ready;
`ifdef PALETTE_TRANSPARENT_EN
    logic        m_col_transparent;
`endif

    always #5 aclk = ~aclk;

    palette_pixel_lookup #(
        .OFFSET     (16'h8000),
        .LINE_WIDTH (4)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_pix_index   (s_pix_index),
        .s_pix_valid   (s_pix_valid),
        .s_pix_ready   (s_pix_ready),
        .palette_bank  (palette_bank),
        .portb_address (portb_address),
        .portb_data    (portb_data),
        .m_col_data    (m_col_data),
        .m_col_last    (m_col_last),
        .m_col_valid   (m_col_valid),
`ifdef PALETTE_TRANSPARENT_EN
        .m_col_transparent (m_col_transparent),
`endif
        .m_col_ready   (m_col_ready)
    );

    // Colour table port B: registered read, one clock latency.
    logic [15:0] rel_addr;
    assign rel_addr = portb_address - 16'h8000;
    always @(posedge aclk) portb_data <= 16'hA000 + (rel_addr >> 1);

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  index;
        logic [3:0]  bank;
        logic [15:0] colour;
        logic        last;
        logic        transparent;
    } vec_t;

    localparam int NVEC = 1033;
    vec_t vec [NVEC];

    int n_vec  = 0;
    int n_fail = 0;
    int acc_first, acc_last, out_first, out_last;

    task automatic check(input string name, input int tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] idx, input logic [3:0] bank, input int pos);
        vec[i].index       = idx;
        vec[i].bank        = bank;
        vec[i].colour      = 16'hA000 + {4'h0, bank, idx};
        vec[i].last        = ((pos % 4) == 3);
        vec[i].transparent = (idx == 8'h00);
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k / 4) % 2 == 0) ? ((k % 4) == 0 || (k % 4) == 3)
                                               : 1'($urandom_range(0, 1));
            default: return (k >= 8);
        endcase
    endfunction

    // Streams vec[first .. first+n-1] in and checks every presented output against it.
    task automatic run_phase(input int first, input int n, input int mode);
        int acc, got, budget;
        acc = 0;
        got = 0;
        budget = 8 * n + 50;
        fork
            begin
                int t;
                t = 0;
                s_pix_valid = 1'b1;
                while (acc < n && t < budget) begin
                    s_pix_index  = vec[first + acc].index;
                    palette_bank = vec[first + acc].bank;
                    if (s_pix_ready) begin
                        if (acc == 0) acc_first = cyc;
                        acc_last = cyc;
                        acc++;
                    end
                    @(negedge aclk);
                    t++;
                end
                s_pix_valid = 1'b0;
            end
            begin
                int k;
                k = 0;
                while (got < n && k < budget) begin
                    m_col_ready = ready_for(mode, k);
                    if (mode == 2 && k == 8) begin
                        check("stall_accepts", first, acc, 3);
                        check("stall_ready", first, s_pix_ready, 1'b0);
                    end
                    if (m_col_valid) begin
                        check("colour", first + got, m_col_data, vec[first + got].colour);
                        check("last", first + got, m_col_last, vec[first + got].last);
`ifdef PALETTE_TRANSPARENT_EN
                        check("transparent", first + got, m_col_transparent, vec[first + got].transparent);
`endif
                        if (m_col_ready) begin
                            if (got == 0) out_first = cyc;
                            out_last = cyc;
                            got++;
                        end
                    end
                    @(negedge aclk);
                    k++;
                end
                m_col_ready = 1'b0;
            end
        join
        check("accepted", first, acc, n);
        check("delivered", first, got, n);
    endtask

    initial begin
        int n, guard;
        areset       = 1'b1;
        s_pix_valid  = 1'b0;
        s_pix_index  = 8'h55;
        palette_bank = 4'h7;
        m_col_ready  = 1'b1;

        for (int i = 0; i < 8; i++)    set_vec(i, 8'(i), 4'h0, i);
        for (int i = 0; i < 3; i++)    set_vec(8 + i, 8'(8'h40 + i), 4'h1, 8 + i);
        for (int i = 0; i < 1000; i++) set_vec(11 + i, 8'((i * 37 + 1) % 256), 4'((i * 5) % 16), 11 + i);
        for (int i = 0; i < 12; i++)   set_vec(1011 + i, 8'(200 + i), 4'h2, i);
        for (int i = 0; i < 3; i++)    set_vec(1023 + i, 8'(9 + i), 4'h4, 0);
        for (int i = 0; i < 4; i++)    set_vec(1026 + i, 8'(20 + i), 4'h6, i);
        set_vec(1030, 8'h00, 4'h0, 4);
        set_vec(1031, 8'h01, 4'h0, 5);
        set_vec(1032, 8'h00, 4'h0, 6);

        repeat (3) @(negedge aclk);
        check("rst_ready", 0, s_pix_ready, 1'b0);
        check("rst_valid", 0, m_col_valid, 1'b0);
        check("rst_data", 0, m_col_data, 16'h0000);
        check("rst_last", 0, m_col_last, 1'b0);
        check("rst_addr", 0, portb_address, 16'h8000);
`ifdef PALETTE_TRANSPARENT_EN
        check("rst_transparent", 0, m_col_transparent, 1'b0);
`endif
        areset = 1'b0;
        #1 check("ready_hold", 0, s_pix_ready, 1'b0);
        @(negedge aclk);
        check("ready_rise", 0, s_pix_ready, 1'b1);

        palette_bank = 4'h3;
        s_pix_index  = 8'h05;
        #1 check("addr_bank3", 0, portb_address, 16'h860A);
        palette_bank = 4'hF;
        s_pix_index  = 8'hFF;
        #1 check("addr_top", 0, portb_address, 16'h9FFE);
        @(negedge aclk);

        run_phase(0, 8, 0);
        check("latency", 0, out_first - acc_first, 2);
        check("in_rate", 0, acc_last - acc_first, 7);
        check("out_rate", 0, out_last - out_first, 7);

        run_phase(8, 3, 2);
        run_phase(11, 1000, 1);

        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        run_phase(1011, 12, 0);

        // Two colours held, one read in flight, then a one-clock reset.
        m_col_ready = 1'b0;
        s_pix_valid = 1'b1;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 20) begin
            s_pix_index  = vec[1023 + n].index;
            palette_bank = vec[1023 + n].bank;
            if (s_pix_ready) n++;
            @(negedge aclk);
            guard++;
        end
        s_pix_valid = 1'b0;
        check("mid_accepts", 1023, n, 3);
        check("mid_valid", 1023, m_col_valid, 1'b1);
        check("mid_head", 1023, m_col_data, vec[1023].colour);
        areset = 1'b1;
        @(negedge aclk);
        check("mid_rst_valid", 1023, m_col_valid, 1'b0);
        check("mid_rst_ready", 1023, s_pix_ready, 1'b0);
        areset = 1'b0;
        @(negedge aclk);
        check("mid_flushed", 1023, m_col_valid, 1'b0);
        check("mid_ready", 1023, s_pix_ready, 1'b1);
        run_phase(1026, 4, 0);
        repeat (3) @(negedge aclk);
        check("drained", 1026, m_col_valid, 1'b0);

`ifdef PALETTE_TRANSPARENT_EN
        run_phase(1030, 3, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
